// File: rtl/moving_average_inverse_pkg.sv
// package_settings: shared widths, FSM states and window decode for the moving-average inverse
package package_settings;
  localparam int SIZE_SHAPER_DATA = 16;
  localparam int SIZE_MOVING_AVERAGE_WINDOW = 8;
  localparam int SIZE_MOVING_AVERAGE_MAX_WINDOW = 64;
  typedef enum logic [1:0] {IDLE, CLEAR, FILL, RUN} inv_state_t;
  // 7 flags any window that is not a power of two in 1..64
  function automatic logic [2:0] window_to_log2(input logic [SIZE_MOVING_AVERAGE_WINDOW-1:0] window);
    logic [2:0] r;
    r = 3'd7;
    for (int i = 0; i < 7; i++)
      if (window == SIZE_MOVING_AVERAGE_WINDOW'(1 << i)) r = 3'(i);
    return r;
  endfunction
endpackage

// File: rtl/moving_average_inverse_if.sv
// moving_average_inverse_if: sample/window bus; sat_flag exists only with MOVING_AVERAGE_INVERSE_SATURATE_EN
interface moving_average_inverse_if;
  import package_settings::*;
  logic signed [SIZE_SHAPER_DATA-1:0] input_data;
  logic input_valid;
  logic [SIZE_MOVING_AVERAGE_WINDOW-1:0] window_set;
  logic signed [SIZE_SHAPER_DATA-1:0] output_data;
  logic output_valid;
  logic settled;
  logic window_error;
`ifdef MOVING_AVERAGE_INVERSE_SATURATE_EN
  logic sat_flag;
`endif
  modport master(output input_data, input_valid, window_set,
                 input output_data, output_valid, settled, window_error
`ifdef MOVING_AVERAGE_INVERSE_SATURATE_EN
                 , sat_flag
`endif
  );
  modport slave(input input_data, input_valid, window_set,
                output output_data, output_valid, settled, window_error
`ifdef MOVING_AVERAGE_INVERSE_SATURATE_EN
                , sat_flag
`endif
  );
endinterface

// File: rtl/moving_average_inverse_history.sv
// moving_average_history: reconstructed-sample shift register with sync clear and a tap at N-1
module moving_average_history
  import package_settings::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic shift,
  input  logic [5:0] tap_sel,
  input  logic signed [SIZE_SHAPER_DATA-1:0] din,
  output logic signed [SIZE_SHAPER_DATA-1:0] tap
);
  logic signed [SIZE_SHAPER_DATA-1:0] mem [SIZE_MOVING_AVERAGE_MAX_WINDOW];
  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) mem <= '{default: '0};
    else if (shift) begin
      mem[0] <= din;
      for (int i = 1; i < SIZE_MOVING_AVERAGE_MAX_WINDOW; i++) mem[i] <= mem[i-1];
    end
  end
  assign tap = mem[tap_sel];
endmodule

// File: rtl/moving_average_inverse.sv
// moving_average_inverse: rebuilds x[n] = x[n-N] + N*(y[n]-y[n-1]) from a boxcar-averaged stream
// MOVING_AVERAGE_INVERSE_SATURATE_EN clamps x to the sample range and adds a sticky sat_flag; otherwise x wraps
module moving_average_inverse
  import package_settings::*;
(
  input logic clk,
  input logic reset,
  moving_average_inverse_if.slave bus
);
  localparam int W = SIZE_SHAPER_DATA;
`ifdef MOVING_AVERAGE_INVERSE_SATURATE_EN
  localparam int DW = W + 7;
`else
  localparam int DW = W;
`endif
  inv_state_t state, state_nxt;
  logic [SIZE_MOVING_AVERAGE_WINDOW-1:0] win_q;
  logic [2:0] log2n;
  logic [6:0] n_m1, fill_cnt;
  logic change, set_legal, active, s1_fire, s2_fire, last, v1;
  logic signed [W-1:0] y_prev, tap, x_out, out_q;
  logic signed [DW-1:0] d, x;
  logic ov_q, settled_q, werr_q;
  assign log2n = window_to_log2(win_q);
  assign n_m1 = (7'd1 << log2n) - 7'd1;
  assign change = win_q != bus.window_set;
  assign set_legal = window_to_log2(bus.window_set) != 3'd7;
  // a window change wins over a same-cycle sample and drops anything in flight
  assign active = (state == FILL || state == RUN) && !change;
  assign s1_fire = active && bus.input_valid;
  assign s2_fire = active && v1;
  assign last = fill_cnt == n_m1;
  assign x = d + DW'(tap);
`ifdef MOVING_AVERAGE_INVERSE_SATURATE_EN
  logic hi, lo, sat_q;
  assign hi = !x[DW-1] && (|x[DW-2:W-1]);
  assign lo = x[DW-1] && !(&x[DW-2:W-1]);
  assign x_out = hi ? {1'b0, {(W-1){1'b1}}} : lo ? {1'b1, {(W-1){1'b0}}} : x[W-1:0];
  assign bus.sat_flag = sat_q;
`else
  assign x_out = x;
`endif
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = set_legal ? CLEAR : IDLE;
    else if (state == CLEAR) state_nxt = FILL;
    else if (change) state_nxt = set_legal ? CLEAR : IDLE;
    else if (state == FILL && s2_fire && last) state_nxt = RUN;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      win_q <= '0;
      werr_q <= 1'b0;
      y_prev <= '0;
      d <= '0;
      v1 <= 1'b0;
      out_q <= '0;
      ov_q <= 1'b0;
      fill_cnt <= '0;
      settled_q <= 1'b0;
`ifdef MOVING_AVERAGE_INVERSE_SATURATE_EN
      sat_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      win_q <= bus.window_set;
      werr_q <= !set_legal;
      if (state == CLEAR) begin
        y_prev <= '0;
        v1 <= 1'b0;
        ov_q <= 1'b0;
        fill_cnt <= '0;
        settled_q <= 1'b0;
`ifdef MOVING_AVERAGE_INVERSE_SATURATE_EN
        sat_q <= 1'b0;
`endif
      end else begin
        v1 <= s1_fire;
        ov_q <= s2_fire;
        if (s1_fire) begin
          d <= (DW'(bus.input_data) - DW'(y_prev)) <<< log2n;
          y_prev <= bus.input_data;
        end
        if (s2_fire) begin
          out_q <= x_out;
          if (state == FILL) fill_cnt <= fill_cnt + 7'd1;
          if (state == FILL && last) settled_q <= 1'b1;
`ifdef MOVING_AVERAGE_INVERSE_SATURATE_EN
          if (hi || lo) sat_q <= 1'b1;
`endif
        end
      end
    end
  end
  moving_average_history u_history (
    .clk(clk),
    .reset(reset),
    .clear(state == CLEAR),
    .shift(s2_fire),
    .tap_sel(n_m1[5:0]),
    .din(x_out),
    .tap(tap)
  );
  assign bus.output_data = out_q;
  assign bus.output_valid = ov_q;
  assign bus.settled = settled_q;
  assign bus.window_error = werr_q;
endmodule

// File: tb/tb_moving_average_inverse.sv
// tb_moving_average_inverse: directed checks of reset, N=4/1/8/16/64 reconstruction, gaps and illegal windows
module tb_moving_average_inverse;
  import package_settings::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  moving_average_inverse_if ifc();
  moving_average_inverse dut (.clk(clk), .reset(reset), .bus(ifc));
  int checks = 0;
  int errors = 0;
  logic signed [15:0] got[$];
  logic set_q[$];
  logic signed [15:0] y4[8] = '{0, 0, 25, 50, 75, 100, 100, 100};
  int e4[8] = '{0, 0, 100, 100, 100, 100, 100, 100};
  always @(negedge clk)
    if (ifc.output_valid === 1'b1) begin
      got.push_back(ifc.output_data);
      set_q.push_back(ifc.settled);
    end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send(logic signed [15:0] y);
    ifc.input_valid = 1'b1;
    ifc.input_data = y;
    tick();
    ifc.input_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    ifc.input_valid = 1'b0;
    ifc.input_data = '0;
    ifc.window_set = 8'd4;
    tick(2);
    chk("rst_ov", ifc.output_valid, 0);
    chk("rst_data", ifc.output_data, 0);
    chk("rst_settled", ifc.settled, 0);
    chk("rst_werr", ifc.window_error, 0);
    reset = 1'b0;
    tick(3);
    got.delete();
    set_q.delete();
    for (int i = 0; i < 8; i++) send(y4[i]);
    tick(3);
    chk("n4_count", got.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("n4_out%0d", i), got[i], e4[i]);
    chk("n4_settled3", set_q[2], 0);
    chk("n4_settled4", set_q[3], 1);
    ifc.input_valid = 1'b1;
    ifc.input_data = 16'sd100;
    tick(3);
    chk("mid_ov_before", ifc.output_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_ov", ifc.output_valid, 0);
    chk("mid_data", ifc.output_data, 0);
    chk("mid_settled", ifc.settled, 0);
    ifc.input_valid = 1'b0;
    #3;
    reset = 1'b0;
    tick(3);
    got.delete();
    send(16'sd25);
    tick(3);
    chk("post_rst_count", got.size(), 1);
    chk("post_rst_out", got[0], 100);
    ifc.window_set = 8'd1;
    tick(3);
    ifc.input_valid = 1'b1;
    ifc.input_data = 16'sd5;
    tick();
    chk("n1_lat", ifc.output_valid, 0);
    ifc.input_data = -16'sd3;
    tick();
    chk("n1_ov0", ifc.output_valid, 1);
    chk("n1_out0", ifc.output_data, 5);
    chk("n1_settled", ifc.settled, 1);
    ifc.input_data = 16'sd7;
    tick();
    chk("n1_out1", ifc.output_data, -3);
    ifc.input_valid = 1'b0;
    tick();
    chk("n1_out2", ifc.output_data, 7);
    tick();
    chk("n1_ov_end", ifc.output_valid, 0);
    chk("n1_hold", ifc.output_data, 7);
    ifc.window_set = 8'd8;
    tick(3);
    got.delete();
    for (int n = 0; n < 12; n++) begin
      send(16'(8 * (n + 1)));
      tick(int'($urandom_range(0, 3)));
    end
    tick(3);
    chk("gap_count", got.size(), 12);
    for (int n = 0; n < 12; n++) chk($sformatf("gap_out%0d", n), got[n], n < 8 ? 64 : 128);
    ifc.window_set = 8'd3;
    tick(2);
    chk("ill_werr", ifc.window_error, 1);
    got.delete();
    send(16'sd9);
    tick(3);
    chk("ill_count", got.size(), 0);
    chk("ill_ov", ifc.output_valid, 0);
    ifc.window_set = 8'd16;
    tick(3);
    chk("n16_werr", ifc.window_error, 0);
    chk("n16_settled", ifc.settled, 0);
    send(16'sd5);
    tick(3);
    chk("n16_count", got.size(), 1);
    chk("n16_out", got[0], 80);
    ifc.window_set = 8'd64;
    tick(3);
    got.delete();
    send(16'sd0);
    send(16'sd600);
    tick(3);
    chk("sat_count", got.size(), 2);
    chk("sat_out0", got[0], 0);
`ifdef MOVING_AVERAGE_INVERSE_SATURATE_EN
    chk("sat_out1", got[1], 32767);
    chk("sat_flag", ifc.sat_flag, 1);
`else
    chk("wrap_out1", got[1], -27136);
`endif
    chk("n64_werr", ifc.window_error, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
